// File: rtl/pll_lock_reset_seq_if.sv
// Lock-flag / design-reset bundle between the PLL lock sequencer and its consumers.
interface pll_lock_reset_seq_if #(
  parameter int LOSS_W = 8
);
  logic              locked_in;
  logic              rst_out;
  logic              ready;
  logic [LOSS_W-1:0] lock_loss_count;
  logic [1:0]        state;

  modport master (input locked_in, output rst_out, ready, lock_loss_count, state);
  modport slave  (output locked_in, input rst_out, ready, lock_loss_count, state);
endinterface

// File: rtl/pll_lock_reset_seq.sv
// Synchronises the raw PLL lock flag, qualifies it, and sequences a registered design
// reset that only releases after stable lock; counts RUN->WAIT_LOCK lock losses.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 16,
  parameter int LOSS_W        = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pll_lock_reset_seq_if.master  bus
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] QUALIFY   = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX    = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOSS_W-1:0]      loss_q, loss_d;
  logic                   rst_q, rdy_q;

  // Only this shift register touches the asynchronous lock flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (!locked_s)                  state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = HOLD;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      HOLD: begin
        if (!locked_s)                state_d = WAIT_LOCK;
        else if (cnt_q == HOLD_LAST)  state_d = RUN;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != LOSS_MAX) loss_d = loss_q + 1'b1;
        end
      end
    endcase
  end

  // Outputs are flops fed from state_d so they change on the same edge as state_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= '0;
      rst_q   <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      rst_q   <= (state_d != RUN);
      rdy_q   <= (state_d == RUN);
    end
  end

  assign bus.rst_out         = rst_q;
  assign bus.ready           = rdy_q;
  assign bus.lock_loss_count = loss_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with SYNC=2, STABLE=8, HOLD=4, LOSS_W=2.
module tb_pll_lock_reset_seq;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  pll_lock_reset_seq_if #(.LOSS_W(2)) bus ();

  pll_lock_reset_seq #(
    .SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(4), .CNT_W(16), .LOSS_W(2)
  ) dut (
    .clock(clk), .reset_n(reset_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic apply_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    bus.locked_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n       = 1'b0;
    bus.locked_in = 1'b0;
    #1;
    n_cmp++; if (bus.rst_out !== 1'b1) begin n_bad++; $display("FAIL reset_rst_out got %b want 1", bus.rst_out); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", bus.state); end
    n_cmp++; if (bus.lock_loss_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.lock_loss_count); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_clean_acquire();
    @(negedge clk);
    bus.locked_in = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL acq_state_e2 got %0d want 0", bus.state); end
      end
      if (e == 3) begin
        n_cmp++; if (bus.state !== 2'd1) begin n_bad++; $display("FAIL acq_state_e3 got %0d want 1", bus.state); end
      end
      if (e == 11) begin
        n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL acq_state_e11 got %0d want 2", bus.state); end
      end
      if (e <= 14) begin
        n_cmp++; if (bus.rst_out !== 1'b1) begin n_bad++; $display("FAIL acq_rst_early e%0d got %b want 1", e, bus.rst_out); end
      end else begin
        n_cmp++; if (bus.rst_out !== 1'b0) begin n_bad++; $display("FAIL acq_rst_out got %b want 0", bus.rst_out); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL acq_ready got %b want 1", bus.ready); end
        n_cmp++; if (bus.state !== 2'd3) begin n_bad++; $display("FAIL acq_state got %0d want 3", bus.state); end
        n_cmp++; if (bus.lock_loss_count !== 2'd0) begin n_bad++; $display("FAIL acq_count got %0d want 0", bus.lock_loss_count); end
      end
    end
  endtask

  task automatic test_glitch_qualify();
    apply_reset();
    @(negedge clk);
    bus.locked_in = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk); #1;
      if (e == 8) begin
        n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL glitch_state_e8 got %0d want 0", bus.state); end
      end
      if (e == 9) begin
        n_cmp++; if (bus.state !== 2'd1) begin n_bad++; $display("FAIL glitch_state_e9 got %0d want 1", bus.state); end
      end
      if (e == 17) begin
        n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL glitch_state_e17 got %0d want 2", bus.state); end
      end
      if (e <= 20) begin
        n_cmp++; if (bus.rst_out !== 1'b1) begin n_bad++; $display("FAIL glitch_rst e%0d got %b want 1", e, bus.rst_out); end
      end else begin
        n_cmp++; if (bus.rst_out !== 1'b0) begin n_bad++; $display("FAIL glitch_rst_release got %b want 0", bus.rst_out); end
        n_cmp++; if (bus.lock_loss_count !== 2'd0) begin n_bad++; $display("FAIL glitch_count got %0d want 0", bus.lock_loss_count); end
      end
      // One-cycle low pulse on the raw flag spanning edge 6.
      @(negedge clk);
      if (e == 5) bus.locked_in = 1'b0;
      if (e == 6) bus.locked_in = 1'b1;
    end
  endtask

  task automatic test_loss_in_run(input logic [1:0] exp_cnt, input string tag);
    @(negedge clk);
    bus.locked_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.rst_out !== 1'b0) begin n_bad++; $display("FAIL %s_rst_e2 got %b want 0", tag, bus.rst_out); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rst_out !== 1'b1) begin n_bad++; $display("FAIL %s_rst got %b want 1", tag, bus.rst_out); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL %s_ready got %b want 0", tag, bus.ready); end
    n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL %s_state got %0d want 0", tag, bus.state); end
    n_cmp++; if (bus.lock_loss_count !== exp_cnt) begin n_bad++; $display("FAIL %s_count got %0d want %0d", tag, bus.lock_loss_count, exp_cnt); end
    @(negedge clk);
    bus.locked_in = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    n_cmp++; if (bus.rst_out !== 1'b1) begin n_bad++; $display("FAIL %s_reacq_e14 got %b want 1", tag, bus.rst_out); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rst_out !== 1'b0) begin n_bad++; $display("FAIL %s_reacq_e15 got %b want 0", tag, bus.rst_out); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    test_clean_acquire();
    for (int i = 0; i < 5; i++) test_loss_in_run(exp_seq[i], $sformatf("sat%0d", i));
  endtask

  task automatic test_async_reset_hold();
    // Enters with count saturated at 3 and the design in RUN.
    @(negedge clk);
    bus.locked_in = 1'b0;
    repeat (4) @(negedge clk);
    bus.locked_in = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (bus.state !== 2'd2) begin n_bad++; $display("FAIL ar_pre_state got %0d want 2", bus.state); end
    n_cmp++; if (bus.lock_loss_count !== 2'd3) begin n_bad++; $display("FAIL ar_pre_count got %0d want 3", bus.lock_loss_count); end
    #5;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.rst_out !== 1'b1) begin n_bad++; $display("FAIL ar_rst got %b want 1", bus.rst_out); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL ar_ready got %b want 0", bus.ready); end
    n_cmp++; if (bus.state !== 2'd0) begin n_bad++; $display("FAIL ar_state got %0d want 0", bus.state); end
    n_cmp++; if (bus.lock_loss_count !== 2'd0) begin n_bad++; $display("FAIL ar_count got %0d want 0", bus.lock_loss_count); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    n_cmp++; if (bus.rst_out !== 1'b1) begin n_bad++; $display("FAIL ar_reacq_e14 got %b want 1", bus.rst_out); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rst_out !== 1'b0) begin n_bad++; $display("FAIL ar_reacq_e15 got %b want 0", bus.rst_out); end
  endtask

  task automatic test_never_locked();
    int bad_cycles;
    bad_cycles = 0;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.state !== 2'd0 || bus.rst_out !== 1'b1 || bus.lock_loss_count !== 2'd0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL never_locked bad cycles %0d want 0 (last state %0d rst %b count %0d)",
               bad_cycles, bus.state, bus.rst_out, bus.lock_loss_count);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b1;
    bus.locked_in = 1'b0;
    test_reset();
    test_clean_acquire();
    test_loss_in_run(2'd1, "loss");
    test_glitch_qualify();
    test_saturation();
    test_async_reset_hold();
    test_never_locked();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pll_lock_reset_seq.md
# pll_lock_reset_seq

Consumer side of the PLL `locked` interface: takes the raw, asynchronous lock flag from a board PLL such as the 150/25 MHz ULX3S PLL. It synchronises and qualifies the flag, then sequences a clean design reset that releases only after lock has been continuously stable. It re-asserts that reset on any loss of lock. It runs on the always-present 25 MHz board oscillator, sits between the PLL instance and the top-level design reset tree, and counts lock-loss events for debug.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on `locked_in`; legal values ≥ 2.
- `STABLE_CYCLES`, 1024: consecutive synchronised-high cycles required before lock is accepted; legal range ≥ 1 and < 2^`CNT_W`.
- `HOLD_CYCLES`, 16: additional cycles `rst_out` stays asserted after lock is accepted; legal range ≥ 1 and < 2^`CNT_W`.
- `CNT_W`, 16: width of the shared qualify/hold counter.
- `LOSS_W`, 8: width of the lock-loss counter.
- `clock`, in, 1: 25 MHz board oscillator, not a PLL output.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `locked_in`, in, 1: raw PLL lock flag, asynchronous to `clock`.
- `rst_out`, out, 1: active-high design reset, registered and synchronous to `clock`.
- `ready`, out, 1: registered; equals `~rst_out`.
- `lock_loss_count`, out, `LOSS_W`: count of RUN→WAIT_LOCK transitions; saturates at all-ones.
- `state`, out, 2: current FSM state, for debug.

## Operation
- Synchroniser: `locked_in` passes through `SYNC_STAGES` flops, all cleared by reset. The last stage is `locked_s`. No other logic samples `locked_in`.
- FSM state encoding: WAIT_LOCK=0, QUALIFY=1, HOLD=2, RUN=3.
- Reset values: state WAIT_LOCK, counter 0, `rst_out`=1, `ready`=0, `lock_loss_count`=0, synchroniser 0.
- WAIT_LOCK:
  - If `locked_s`=1, go to QUALIFY and set counter to 0.
- QUALIFY:
  - If `locked_s`=0, go to WAIT_LOCK. The counter clears and `lock_loss_count` does not change.
  - Else if counter == `STABLE_CYCLES`-1, go to HOLD and set counter to 0.
  - Else increment the counter.
- HOLD:
  - If `locked_s`=0, go to WAIT_LOCK. `lock_loss_count` does not change.
  - Else if counter == `HOLD_CYCLES`-1, go to RUN.
  - Else increment the counter.
- RUN:
  - If `locked_s`=0, go to WAIT_LOCK, clear the counter, and increment `lock_loss_count` unless it is already all-ones.
- `rst_out` and `ready` are dedicated flops. They update on the same edge as the state register, so `rst_out`=0 exactly while state==RUN. Neither output ever glitches combinationally.
- The counter never wraps, because the parameter range is constrained. In states where it is unused it holds 0.
- Asynchronous `reset_n` assertion at any point returns every output to its reset value immediately, without waiting for a clock edge. Release is synchronous to the next `clock` edge. Sequencing then restarts from WAIT_LOCK.

## Timing
- Acquire latency: `locked_in` is high before edge 0 and stays high. `locked_s` is 1 after `SYNC_STAGES` edges. `rst_out` falls on edge `SYNC_STAGES` + 1 + `STABLE_CYCLES` + `HOLD_CYCLES`. With default parameters this is edge 1043.
- Loss latency: `locked_in` falls before edge 0. `rst_out` rises and `lock_loss_count` increments on edge `SYNC_STAGES` + 1.
- A glitch on `locked_in` during QUALIFY restarts qualification in full. It must be at least one `clock` period long to be seen after synchronisation.
- Simultaneous events: the lock drop in RUN occurs at the same edge the counter would saturate. The state still goes to WAIT_LOCK, `rst_out`=1, and the count stays at all-ones.
- Minimum `rst_out` assertion after any loss of lock: 1 + `STABLE_CYCLES` + `HOLD_CYCLES` cycles.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `STABLE_CYCLES`=8, `HOLD_CYCLES`=4, `LOSS_W`=2.
- **Clean acquire.** Release `reset_n`, then raise `locked_in` before edge 0 and hold it high. Required: `rst_out`=1 through edge 14, `rst_out`=0 and `ready`=1 from edge 15, state=3, `lock_loss_count`=0.
- **Glitch during QUALIFY.** Hold `locked_in` high, drop it for 1 cycle at cycle 6, then hold it high again. Required: state returns to 0, the full 8+4 qualify/hold sequence restarts, `rst_out` stays 1 throughout, and the count stays 0.
- **Loss in RUN.** From RUN, drop `locked_in` before edge 0. Required: `rst_out`=1, `ready`=0, state=0 and `lock_loss_count`=1 at edge 3. Reacquire then takes 15 edges again.
- **Saturation.** Perform 5 RUN→loss cycles. Required: `lock_loss_count` reads 1, 2, 3, 3, 3.
- **Async reset mid-HOLD.** Assert `reset_n`=0 between edges while state=2. Required: `rst_out`=1, `ready`=0, state=0 and the count cleared before the next edge. After release with `locked_in` still high, `rst_out` falls 15 edges later.
- **Lock never asserted.** Hold `locked_in`=0 for 2000 cycles. Required: state stays 0, `rst_out`=1, count 0.
